// File: rtl/bm_dag_sched_pkg.sv
// Shared constants for the round-robin add scheduler and its arbiter.
package bm_dag_sched_pkg;

  localparam int unsigned BITS_DEF = 2;
  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned ID_W     = $clog2(NREQ_DEF);
  localparam int unsigned CNT_W    = 8;

endpackage

// File: rtl/bm_dag_rr_arb.sv
// Round-robin arbiter: grants the first asserted request at or after ptr.
module bm_dag_rr_arb
  import bm_dag_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          grant_c,
  output logic [$clog2(NREQ)-1:0]  grant_idx_c,
  output logic                     accept_c
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cand;

  // NREQ is a power of two, so the index sum wraps modulo NREQ on its own.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    accept_c    = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr_q + IDW'(k);
      if (!accept_c && en && reset_n && req[cand]) begin
        accept_c    = 1'b1;
        grant_idx_c = cand;
      end
    end
    if (accept_c) grant_c[grant_idx_c] = 1'b1;
    ptr_d = accept_c ? grant_idx_c + IDW'(1) : ptr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bm_dag_sched.sv
// Two-stage carry-save adder pipeline fed by a round-robin arbiter.
module bm_dag_sched
  import bm_dag_sched_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEF,
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BITS-1:0]     a_flat,
  input  logic [NREQ*BITS-1:0]     b_flat,
  output logic [NREQ-1:0]          grant,
  output logic                     out_valid,
  output logic [BITS-1:0]          out_data,
  output logic [$clog2(NREQ)-1:0]  out_id,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         done_cnt
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic            adv_c, acc_c;
  logic [IDW-1:0]  gidx_c;
  logic [BITS-1:0] op_a_c, op_b_c;

  logic            s1_v_q, s1_v_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic [BITS-1:0] s1_x_q, s1_x_d, s1_c_q, s1_c_d;
  logic            out_valid_q, out_valid_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic [BITS-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic            busy_q, busy_d;

  assign adv_c = !out_valid_q || out_ready;

  bm_dag_rr_arb #(.NREQ(NREQ)) u_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .en          (adv_c),
    .req         (req),
    .grant_c     (grant),
    .grant_idx_c (gidx_c),
    .accept_c    (acc_c)
  );

  assign op_a_c = a_flat[gidx_c*BITS +: BITS];
  assign op_b_c = b_flat[gidx_c*BITS +: BITS];

  // Stage 1 keeps sum/carry split; stage 2 resolves the carry.
  always_comb begin
    s1_v_d      = s1_v_q;
    s1_id_d     = s1_id_q;
    s1_x_d      = s1_x_q;
    s1_c_d      = s1_c_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    done_cnt_d  = done_cnt_q;
    if (adv_c) begin
      s1_v_d      = acc_c;
      out_valid_d = s1_v_q;
      out_id_d    = s1_id_q;
      out_data_d  = s1_x_q + (s1_c_q << 1);
    end
    if (acc_c) begin
      s1_id_d = gidx_c;
      s1_x_d  = op_a_c ^ op_b_c;
      s1_c_d  = op_a_c & op_b_c;
    end
    if (out_valid_q && out_ready) done_cnt_d = done_cnt_q + CNT_W'(1);
    busy_d = s1_v_d | out_valid_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q      <= 1'b0;
      s1_id_q     <= '0;
      s1_x_q      <= '0;
      s1_c_q      <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      done_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_id_q     <= s1_id_d;
      s1_x_q      <= s1_x_d;
      s1_c_q      <= s1_c_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      done_cnt_q  <= done_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign done_cnt  = done_cnt_q;
  assign busy      = busy_q;

endmodule
